hash_byte_feeder: RTL and testbench

- Producer end of the hash core's byte interface: buffers a message written by a host, then issues start, streams bytes on Byte/F_dr with End_Of_File on the last byte, and honours F_rtr back-pressure.
- Captures the 32-bit digest on H_ready and holds it for the host.
- Sits between the host/file-loader logic and full_hash.
- Includes a completion watchdog.

---
 rtl/hash_byte_feeder.sv | 143 ++++++++++++++
 tb/tb_hash_byte_feeder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hash_byte_feeder.sv
// Producer side of the hash core byte interface: buffers a host message, streams it
// with start/F_dr/End_Of_File under F_rtr back-pressure, then captures the digest.
module hash_byte_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_full,
    input  logic        go,
    output logic        busy,
    output logic        start,
    output logic [7:0]  Byte,
    output logic        End_Of_File,
    output logic        F_dr,
    input  logic        F_rtr,
    input  logic        H_ready,
    input  logic [31:0] R_h,
    output logic [31:0] digest,
    output logic        digest_valid,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        WAIT_H = 2'd3
    } state_t;

    state_t         state_r, next_state_s;
    logic [8:0]     mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [TW-1:0]  tmo_cnt_r;
    logic           msg_complete_r, busy_r, err_r, digest_valid_r;
    logic [31:0]    digest_r;

    logic           empty_s, full_s, go_ok_s, wr_ok_s, wr_bad_s;
    logic           pop_s, cap_s, tmo_s, start_s, f_dr_s;
    logic [8:0]     head_s;

    assign empty_s  = (count_r == CW'(0));
    assign full_s   = (count_r == CW'(DEPTH));
    assign head_s   = mem_r[rd_ptr_r];
    assign go_ok_s  = (state_r == IDLE) & go & msg_complete_r;
    assign wr_ok_s  = wr_en & (state_r == IDLE) & ~full_s & ~msg_complete_r;
    assign wr_bad_s = wr_en & ~wr_ok_s;
    assign pop_s    = f_dr_s & F_rtr;
    assign cap_s    = (state_r == WAIT_H) & H_ready;
    assign tmo_s    = (state_r == WAIT_H) & ~H_ready & (tmo_cnt_r == TMO_LAST);

    // Next-state and handshake decode
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        f_dr_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (go_ok_s) next_state_s = START;
                else         next_state_s = IDLE;
            end
            START: begin
                start_s      = 1'b1;
                next_state_s = STREAM;
            end
            STREAM: begin
                f_dr_s = ~empty_s;
                if (f_dr_s & F_rtr & head_s[8]) next_state_s = WAIT_H;
                else                            next_state_s = STREAM;
            end
            WAIT_H: begin
                if (cap_s | tmo_s) next_state_s = IDLE;
                else               next_state_s = WAIT_H;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Message storage; contents are don't-care until written, reads are gated by F_dr
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_r[wr_ptr_r] <= {wr_last, wr_data};
    end

    // Buffer pointers, status flags, digest capture and completion watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            msg_complete_r <= 1'b0;
            busy_r         <= 1'b0;
            err_r          <= 1'b0;
            digest_valid_r <= 1'b0;
            digest_r       <= 32'h0000_0000;
            tmo_cnt_r      <= '0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({wr_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (wr_ok_s & wr_last)         msg_complete_r <= 1'b1;
            else if (pop_s & head_s[8])    msg_complete_r <= 1'b0;
            if (go_ok_s)                   busy_r <= 1'b1;
            else if (cap_s | tmo_s)        busy_r <= 1'b0;
            // A dropped write in the same cycle as an accepted go still flags
            err_r <= (err_r & ~go_ok_s) | wr_bad_s | tmo_s;
            if (go_ok_s)                   digest_valid_r <= 1'b0;
            else if (cap_s)                digest_valid_r <= 1'b1;
            if (cap_s)                     digest_r <= R_h;
            if ((state_r == WAIT_H) & ~H_ready & ~tmo_s) tmo_cnt_r <= tmo_cnt_r + TW'(1);
            else                                         tmo_cnt_r <= '0;
        end
    end

    assign wr_full      = full_s;
    assign busy         = busy_r;
    assign start        = start_s;
    assign F_dr         = f_dr_s;
    assign Byte         = f_dr_s ? head_s[7:0] : 8'h00;
    assign End_Of_File  = f_dr_s & head_s[8];
    assign digest       = digest_r;
    assign digest_valid = digest_valid_r;
    assign err          = err_r;

endmodule

// File: tb/tb_hash_byte_feeder.sv
// Directed self-checking bench for hash_byte_feeder (DEPTH=16, TIMEOUT=8).
module tb_hash_byte_feeder;

    logic        clk, rst_n;
    logic        wr_en, wr_last, wr_full, go, busy, start;
    logic [7:0]  wr_data, Byte;
    logic        End_Of_File, F_dr, F_rtr, H_ready, digest_valid, err;
    logic [31:0] R_h, digest;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    hash_byte_feeder #(.DEPTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .wr_full(wr_full), .go(go), .busy(busy), .start(start), .Byte(Byte),
        .End_Of_File(End_Of_File), .F_dr(F_dr), .F_rtr(F_rtr), .H_ready(H_ready),
        .R_h(R_h), .digest(digest), .digest_valid(digest_valid), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic l);
        wr_en = 1'b1; wr_data = d; wr_last = l;
        @(negedge clk);
        wr_en = 1'b0; wr_last = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic finish_hash(input string tag, input logic [31:0] h);
        H_ready = 1'b1; R_h = h;
        @(negedge clk);
        H_ready = 1'b0;
        check({tag, "_digest"}, digest, h);
        check({tag, "_dvalid_busy"}, {30'd0, digest_valid, busy}, 32'h2);
    endtask

    initial begin
        logic [7:0] msg [3];
        logic [7:0] prev;
        logic       held;
        int         n;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0; go = 1'b0;
        F_rtr = 1'b0; H_ready = 1'b0; R_h = 32'h0;
        #1;
        check("reset_flags", {25'd0, wr_full, busy, start, F_dr, End_Of_File, digest_valid, err}, 32'h0);
        check("reset_byte_digest", digest | {24'd0, Byte}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1: basic 3-byte stream with F_rtr held high
        F_rtr = 1'b1;
        wr(8'h61, 1'b0); wr(8'h62, 1'b0); wr(8'h63, 1'b1);
        pulse_go();
        check("t1_start", {29'd0, start, busy, F_dr}, 32'h6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_stream", {21'd0, start, F_dr, End_Of_File, Byte}, {21'd0, 1'b0, 1'b1, (i == 2), msg[i]});
        end
        @(negedge clk);
        check("t1_fdr_drop", {31'd0, F_dr}, 32'h0);
        finish_hash("t1", 32'hDEADBEEF);

        // 2: back-pressure with F_rtr toggling
        wr(8'h61, 1'b0); wr(8'h62, 1'b0); wr(8'h63, 1'b1);
        F_rtr = 1'b0;
        pulse_go();
        n = 0; held = 1'b0; prev = 8'h00;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            F_rtr = c[0];
            if (held) check("t2_hold", {24'd0, Byte}, {24'd0, prev});
            if (F_dr && F_rtr) begin
                check("t2_byte", {23'd0, End_Of_File, Byte}, {23'd0, (n == 2), msg[n]});
                n++;
                held = 1'b0;
            end else begin
                held = F_dr;
                prev = Byte;
            end
        end
        check("t2_count", n, 3);
        F_rtr = 1'b1;
        @(negedge clk);
        check("t2_fdr_drop", {31'd0, F_dr}, 32'h0);
        finish_hash("t2", 32'h12345678);

        // 3: full buffer, overflow write, 16-byte stream
        for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i), (i == 15));
        check("t3_full", {30'd0, wr_full, err}, 32'h2);
        wr(8'hFF, 1'b1);
        check("t3_overflow_err", {30'd0, wr_full, err}, 32'h3);
        pulse_go();
        check("t3_go", {29'd0, err, busy, start}, 32'h3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t3_stream", {22'd0, F_dr, End_Of_File, Byte}, {22'd0, 1'b1, (i == 15), 8'hA0 + 8'(i)});
        end
        @(negedge clk);
        check("t3_fdr_drop", {31'd0, F_dr}, 32'h0);
        finish_hash("t3", 32'h0BADF00D);

        // 4: go without a complete message, write during STREAM
        pulse_go();
        check("t4_go_ignored", {28'd0, start, busy, err, digest_valid}, 32'h1);
        F_rtr = 1'b0;
        wr(8'h11, 1'b0); wr(8'h22, 1'b1);
        pulse_go();
        @(negedge clk);
        check("t4_stream", {23'd0, F_dr, Byte}, {23'd0, 1'b1, 8'h11});
        wr(8'h33, 1'b1);
        check("t4_stream_write_err", {22'd0, err, F_dr, Byte}, {22'd0, 1'b1, 1'b1, 8'h11});
        F_rtr = 1'b1;
        @(negedge clk);
        check("t4_second", {23'd0, End_Of_File, Byte}, {23'd0, 1'b1, 8'h22});
        @(negedge clk);
        check("t4_fdr_drop", {31'd0, F_dr}, 32'h0);
        finish_hash("t4", 32'hCAFEF00D);
        check("t4_err_sticky", {31'd0, err}, 32'h1);

        // 5: watchdog, H_ready never arrives
        wr(8'h77, 1'b1);
        pulse_go();
        check("t5_go_clears_err", {30'd0, err, start}, 32'h1);
        @(negedge clk);
        check("t5_byte", {22'd0, F_dr, End_Of_File, Byte}, {22'd0, 1'b1, 1'b1, 8'h77});
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 8) check("t5_before_timeout", {30'd0, err, busy}, 32'h1);
            if (i == 9) check("t5_timeout", {29'd0, err, busy, digest_valid}, 32'h4);
        end

        // 6: reset during STREAM, then a fresh 1-byte message
        for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i), (i == 4));
        pulse_go();
        @(negedge clk);
        check("t6_b0", {24'd0, Byte}, 32'hC0);
        @(negedge clk);
        check("t6_b1", {24'd0, Byte}, 32'hC1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_reset_flags", {25'd0, wr_full, busy, start, F_dr, End_Of_File, digest_valid, err}, 32'h0);
        check("t6_reset_byte_digest", digest | {24'd0, Byte}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(8'h5A, 1'b1);
        pulse_go();
        check("t6_start", {30'd0, start, busy}, 32'h3);
        @(negedge clk);
        check("t6_byte", {22'd0, F_dr, End_Of_File, Byte}, {22'd0, 1'b1, 1'b1, 8'h5A});
        @(negedge clk);
        check("t6_fdr_drop", {31'd0, F_dr}, 32'h0);
        finish_hash("t6", 32'h13579BDF);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
